// File: rtl/dw3_21_gen.sv
// dw3_21_gen -- delta-weight generator for hidden-to-output weight w3_21.
//
// Purpose:
//   Sequences one weight initialisation followed by N_UPDATES weight updates.
//   Each update takes one (delta3_2, a2_1) operand pair over a valid/ready
//   handshake. It then computes dw3_21 = LR * delta3_2 * a2_1 in signed Q6.10
//   using two registered multiply stages. Each stage rounds by floor
//   (arithmetic shift right by 10).
//
// Parameters:
//   LR         learning rate, signed Q6.10 (512 = 0.5)
//   N_UPDATES  updates issued per run (1..65535)
//
// Configuration macro:
//   DW_SAT_EN  when defined, each shifted product saturates to the 16-bit
//              signed range; otherwise it wraps (low 16 bits kept).
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset
//   start           one-cycle run request, honoured in IDLE/DONE only
//   delta3_2        error term, signed Q6.10
//   a2_1            hidden activation, signed Q6.10
//   in_valid        operand pair valid
//   in_ready        high only while waiting for an operand pair
//   dw3_21          delta weight, signed Q6.10, holds between updates
//   select_initial  one-cycle pulse loading the initial weight
//   select_update   one-cycle pulse applying dw3_21
//   busy            high in every state except IDLE and DONE
//   done            high when the run has completed
//   update_count    updates issued in the current run

module dw3_21_gen #(
  parameter logic signed [15:0] LR        = 16'sd512,
  parameter int unsigned        N_UPDATES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [15:0] delta3_2,
  input  logic signed [15:0] a2_1,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [15:0] dw3_21,
  output logic               select_initial,
  output logic               select_update,
  output logic               busy,
  output logic               done,
  output logic        [15:0] update_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    WAIT  = 3'd2,
    MUL1  = 3'd3,
    MUL2  = 3'd4,
    ISSUE = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [15:0] LAST_COUNT = 16'(N_UPDATES);

  state_t state;
  state_t next_state;

  logic in_ready_nxt;
  logic select_initial_nxt;
  logic select_update_nxt;
  logic busy_nxt;
  logic done_nxt;

  logic signed [15:0] op_delta;
  logic signed [15:0] op_a;
  logic signed [15:0] q1;
  logic signed [31:0] p1;
  logic signed [31:0] p2;

  logic handshake;
  logic run_request;

  // Floor-rounded Q6.10 rescale of a 32-bit product back to 16 bits. The
  // out-of-range behaviour is selected at build time.
  function automatic logic signed [15:0] shift_reduce(input logic signed [31:0] p);
`ifdef DW_SAT_EN
    if ((p >>> 10) > 32'sd32767) begin
      return 16'sh7FFF;
    end else if ((p >>> 10) < -32'sd32768) begin
      return 16'sh8000;
    end else begin
      return 16'(p >>> 10);
    end
`else
    return 16'(p >>> 10);
`endif
  endfunction

  // in_ready is a registered decode of the WAIT state, so it doubles as the
  // "we are in WAIT" qualifier for the handshake.
  assign handshake   = in_valid && in_ready;
  assign run_request = start && ((state == IDLE) || (state == DONE));

  // Full 32-bit signed products; operands are sign-extended explicitly so the
  // multiply is evaluated at full width.
  assign p1 = $signed({{16{op_delta[15]}}, op_delta}) * $signed({{16{op_a[15]}}, op_a});
  assign p2 = $signed({{16{q1[15]}}, q1}) * $signed({{16{LR[15]}}, LR});

  // Next-state logic plus the state-decoded outputs. The decodes are taken
  // from next_state so that, once registered, each output lines up exactly
  // with the cycle spent in its state.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start)     next_state = INIT;
      INIT:                   next_state = WAIT;
      WAIT:    if (handshake) next_state = MUL1;
      MUL1:                   next_state = MUL2;
      MUL2:                   next_state = ISSUE;
      ISSUE:   next_state = (update_count == LAST_COUNT) ? DONE : WAIT;
      DONE:    if (start)     next_state = INIT;
      default:                next_state = IDLE;
    endcase

    in_ready_nxt       = (next_state == WAIT);
    select_initial_nxt = (next_state == INIT);
    select_update_nxt  = (next_state == ISSUE);
    busy_nxt           = (next_state != IDLE) && (next_state != DONE);
    done_nxt           = (next_state == DONE);
  end

  // State register and registered control outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      in_ready       <= 1'b0;
      select_initial <= 1'b0;
      select_update  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= next_state;
      in_ready       <= in_ready_nxt;
      select_initial <= select_initial_nxt;
      select_update  <= select_update_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
    end
  end

  // Datapath: operand capture, the two multiply stages and the update
  // counter. The counter is bumped on entry to ISSUE so its new value is
  // visible alongside select_update, and ISSUE can compare it directly
  // against the run length.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_delta     <= '0;
      op_a         <= '0;
      q1           <= '0;
      dw3_21       <= '0;
      update_count <= '0;
    end else begin
      if (handshake) begin
        op_delta <= delta3_2;
        op_a     <= a2_1;
      end
      if (state == MUL1) begin
        q1 <= shift_reduce(p1);
      end
      if (state == MUL2) begin
        dw3_21 <= shift_reduce(p2);
      end
      if (run_request) begin
        update_count <= '0;
      end else if (state == MUL2) begin
        update_count <= update_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dw3_21_gen.sv
// tb_dw3_21_gen -- scoreboard bench for dw3_21_gen.
//
// The stimulus pushes the expected delta weight into a queue whenever a
// handshake is about to complete. A free-running monitor on the falling edge
// pops one entry per select_update pulse and compares it. The expected
// values come from an arithmetic model of LR * delta * a with floor rounding
// and either wrap or saturation, depending on DW_SAT_EN.

module tb_dw3_21_gen;

  localparam int               N_UPD = 4;
  localparam logic signed [15:0] LR_V = 16'sd512;

  logic               clk;
  logic               reset;
  logic               start;
  logic signed [15:0] delta3_2;
  logic signed [15:0] a2_1;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] dw3_21;
  logic               select_initial;
  logic               select_update;
  logic               busy;
  logic               done;
  logic        [15:0] update_count;

  int n_compared  = 0;
  int n_mismatch  = 0;
  int exp_q[$];
  int pulse_cycles[$];
  int cycle       = 0;
  int mon_count   = 0;
  int init_pulses = 0;

  dw3_21_gen #(
    .LR        (LR_V),
    .N_UPDATES (N_UPD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .delta3_2       (delta3_2),
    .a2_1           (a2_1),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .dw3_21         (dw3_21),
    .select_initial (select_initial),
    .select_update  (select_update),
    .busy           (busy),
    .done           (done),
    .update_count   (update_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Reference model: exact product, floor division by 1024, then fit to
  // 16 bits.
  function automatic longint floor_div1024(input longint v);
    longint r;
    r = ((v % 1024) + 1024) % 1024;
    return (v - r) / 1024;
  endfunction

  function automatic int fit16(input longint v);
    longint m;
`ifdef DW_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    m = v;
`else
    m = ((v % 65536) + 65536) % 65536;
    if (m >= 32768) m = m - 65536;
`endif
    return int'(m);
  endfunction

  function automatic int model_dw(input int d, input int a);
    int q1;
    q1 = fit16(floor_div1024(longint'(d) * longint'(a)));
    return fit16(floor_div1024(longint'(q1) * longint'(int'(LR_V))));
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_compared++;
    if (act != exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %0d, expected %0d at cycle %0d", name, act, exp, cycle);
    end
  endtask

  // Monitor: consumes one expected value per select_update pulse.
  always @(negedge clk) begin
    if (reset) begin
      if (select_initial) init_pulses++;
      if (select_update) begin
        pulse_cycles.push_back(cycle);
        mon_count++;
        check("selects_exclusive", longint'(select_initial), 0);
        if (exp_q.size() == 0) begin
          n_compared++;
          n_mismatch++;
          $display("[TB] FAIL unexpected_update: got dw3_21=%0d, expected no pulse at cycle %0d",
                   dw3_21, cycle);
        end else begin
          check("dw3_21", longint'(dw3_21), longint'(exp_q.pop_front()));
        end
        check("update_count", longint'(update_count), longint'(mon_count));
      end
    end
  end

  task automatic apply_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    mon_count = 0;
    pulse_cycles.delete();
    @(negedge clk);
    check("select_initial_pulse", longint'(select_initial), 1);
    check("busy_in_init", longint'(busy), 1);
    @(negedge clk);
    check("select_initial_single", longint'(select_initial), 0);
    check("in_ready_in_wait", longint'(in_ready), 1);
  endtask

  // Presents an operand pair and returns 1 ns after the edge that accepts it.
  task automatic apply_stimulus(input logic signed [15:0] d, input logic signed [15:0] a,
                                input bit hold);
    bit got;
    got      = 1'b0;
    delta3_2 = d;
    a2_1     = a;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      n_compared++;
      n_mismatch++;
      $display("[TB] FAIL handshake_timeout: got in_ready=0, expected 1 within 100 cycles");
    end else begin
      exp_q.push_back(model_dw(int'(d), int'(a)));
    end
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_reached", longint'(got), 1);
    check("done_busy", longint'(busy), 0);
    check("done_in_ready", longint'(in_ready), 0);
    check("done_count", longint'(update_count), N_UPD);
    check("scoreboard_drained", longint'(exp_q.size()), 0);
  endtask

  initial begin
    int init_before;
    logic signed [15:0] rd;
    logic signed [15:0] ra;

    reset    = 1'b0;
    start    = 1'b0;
    delta3_2 = '0;
    a2_1     = '0;
    in_valid = 1'b0;
    #1;
    check("reset_dw3_21", longint'(dw3_21), 0);
    check("reset_select_initial", longint'(select_initial), 0);
    check("reset_select_update", longint'(select_update), 0);
    check("reset_in_ready", longint'(in_ready), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_done", longint'(done), 0);
    check("reset_update_count", longint'(update_count), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Run 1: directed operand pairs, in_valid dropped between pairs.
    $display("[TB] run 1: directed pairs");
    apply_start();
    apply_stimulus(16'sd512, 16'sd256, 1'b0);
    apply_stimulus(-16'sd1, 16'sd1024, 1'b0);
    apply_stimulus(16'sd32767, 16'sd32767, 1'b0);
    apply_stimulus(-16'sd300, 16'sd700, 1'b0);
    wait_done();
    check("directed_model_basic", longint'(model_dw(512, 256)), 64);

    // A fifth operand pair offered in DONE must not be accepted.
    delta3_2 = 16'sd100;
    a2_1     = 16'sd100;
    in_valid = 1'b1;
    repeat (8) @(negedge clk);
    in_valid = 1'b0;
    check("done_ignores_valid_count", longint'(update_count), N_UPD);
    check("done_ignores_valid_done", longint'(done), 1);

    // Run 2: random pairs, back to back with in_valid held high.
    $display("[TB] run 2: back-to-back random pairs");
    apply_start();
    for (int i = 0; i < N_UPD; i++) begin
      rd = 16'($urandom);
      ra = 16'($urandom);
      apply_stimulus(rd, ra, 1'b1);
    end
    in_valid = 1'b0;
    wait_done();
    check("pulse_total", longint'(pulse_cycles.size()), N_UPD);
    for (int i = 1; i < pulse_cycles.size(); i++) begin
      check("update_spacing", longint'(pulse_cycles[i] - pulse_cycles[i-1]), 4);
    end

    // Run 3: protocol abuse -- start in WAIT and MUL1, in_valid in MUL2.
    $display("[TB] run 3: protocol");
    apply_start();
    init_before = init_pulses;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    rd = 16'($urandom);
    ra = 16'($urandom);
    apply_stimulus(rd, ra, 1'b0);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    delta3_2 = 16'sd1000;
    a2_1     = 16'sd1000;
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("no_extra_select_initial", longint'(init_pulses), longint'(init_before));
    check("no_capture_in_mul2", longint'(update_count), 1);
    for (int i = 1; i < N_UPD; i++) begin
      rd = 16'($urandom);
      ra = 16'($urandom);
      apply_stimulus(rd, ra, 1'b0);
    end
    wait_done();

    // Run 4: reset asserted in MUL2, then a clean run.
    $display("[TB] run 4: reset mid-run");
    apply_start();
    apply_stimulus(16'sd2000, 16'sd3000, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_dw3_21", longint'(dw3_21), 0);
    check("async_reset_busy", longint'(busy), 0);
    check("async_reset_count", longint'(update_count), 0);
    check("async_reset_select_update", longint'(select_update), 0);
    @(posedge clk); #1 reset = 1'b1;
    pulse_cycles.delete();
    repeat (6) @(negedge clk);
    check("no_pulse_after_reset", longint'(pulse_cycles.size()), 0);
    apply_start();
    for (int i = 0; i < N_UPD; i++) begin
      rd = 16'($urandom);
      ra = 16'($urandom);
      apply_stimulus(rd, ra, 1'b0);
    end
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
